// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned GNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    FLUSH = 2'd3
  } arb_state_t;

  localparam logic [GNT_W-1:0] GNT_NONE = 2'b00;
  localparam logic [GNT_W-1:0] GNT_REQ0 = 2'b01;
  localparam logic [GNT_W-1:0] GNT_REQ1 = 2'b10;

  // One requester byte as offered on its port.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
  } req_beat_t;

  // One-hot owner implied by a state.
  function automatic logic [GNT_W-1:0] state_grant(input arb_state_t s);
    case (s)
      GNT0:    state_grant = GNT_REQ0;
      GNT1:    state_grant = GNT_REQ1;
      default: state_grant = GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/flex_counter_reg.sv
// Clearable up-counter with a flag on the increment that reaches rollover_val.
module flex_counter_reg #(
  parameter int unsigned NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag_c
);

  // Flag is high in the cycle whose increment brings the count to rollover_val.
  always_comb begin
    rollover_flag_c = count_enable && (count_out == (rollover_val - NUM_CNT_BITS'(1)));
  end

  // Count register; clear has priority over enable, wraps to zero at rollover.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (rollover_flag_c) count_out <= '0;
      else                 count_out <= count_out + NUM_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-requester packet arbiter in front of a FIFO write port, with flush
// sequencing and a stall watchdog. The abort pulse appears in the IDLE cycle
// that follows the MAX_STALL-th consecutive stall cycle.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned MAX_STALL = 15
) (
  input  logic              w_clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_valid,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_valid,
  input  logic              req1_last,
  output logic              req1_ready,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [DATA_W-1:0] fifo_w_data,
  output logic              fifo_w_enable,
  output logic              fifo_clear,
  input  logic              fifo_full,
  input  logic              fifo_almost_full,
  output logic [GNT_W-1:0]  grant,
  output logic              stall_abort
);

  arb_state_t       state, next_state;
  logic             rr, rr_next;
  logic             abort_next;
  req_beat_t        req [2];
  logic             xfer0, xfer1;
  logic             sel_valid;
  logic             stall, stall_hit, cnt_clear;
  logic [CNT_W-1:0] stall_cnt;

  // Bundle requester ports.
  always_comb begin
    req[0] = '{data: req0_data, valid: req0_valid, last: req0_last};
    req[1] = '{data: req1_data, valid: req1_valid, last: req1_last};
  end

  // Handshake and write path follow the registered grant.
  always_comb begin
    req0_ready    = grant[0] && !fifo_full;
    req1_ready    = grant[1] && !fifo_full;
    xfer0         = req[0].valid && req0_ready;
    xfer1         = req[1].valid && req1_ready;
    fifo_w_enable = xfer0 || xfer1;
    fifo_w_data   = '0;
    sel_valid     = 1'b0;
    if (grant[0]) begin
      fifo_w_data = req[0].data;
      sel_valid   = req[0].valid;
    end else if (grant[1]) begin
      fifo_w_data = req[1].data;
      sel_valid   = req[1].valid;
    end
    stall     = (|grant) && !sel_valid && !fifo_full;
    cnt_clear = fifo_w_enable || !(next_state inside {GNT0, GNT1});
  end

  // Consecutive stall-cycle watchdog.
  flex_counter_reg #(
    .NUM_CNT_BITS(CNT_W)
  ) u_stall_cnt (
    .clk            (w_clk),
    .n_rst          (n_rst),
    .clear          (cnt_clear),
    .count_enable   (stall),
    .rollover_val   (CNT_W'(MAX_STALL)),
    .count_out      (stall_cnt),
    .rollover_flag_c(stall_hit)
  );

  // Next-state, round-robin and abort decision.
  always_comb begin
    next_state = state;
    rr_next    = rr;
    abort_next = 1'b0;
    case (state)
      IDLE: begin
        if (flush_done) begin
          next_state = IDLE;
        end else if (flush_req) begin
          next_state = FLUSH;
        end else if (!fifo_full && !fifo_almost_full) begin
          if (req[0].valid && req[1].valid) next_state = rr ? GNT1 : GNT0;
          else if (req[0].valid)            next_state = GNT0;
          else if (req[1].valid)            next_state = GNT1;
        end
      end
      GNT0: begin
        if (xfer0 && req[0].last) begin
          next_state = IDLE;
          rr_next    = 1'b1;
        end else if (stall_hit) begin
          next_state = IDLE;
          rr_next    = 1'b1;
          abort_next = 1'b1;
        end
      end
      GNT1: begin
        if (xfer1 && req[1].last) begin
          next_state = IDLE;
          rr_next    = 1'b0;
        end else if (stall_hit) begin
          next_state = IDLE;
          rr_next    = 1'b0;
          abort_next = 1'b1;
        end
      end
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      rr          <= 1'b0;
      grant       <= GNT_NONE;
      fifo_clear  <= 1'b0;
      flush_done  <= 1'b0;
      stall_abort <= 1'b0;
    end else begin
      state       <= next_state;
      rr          <= rr_next;
      grant       <= state_grant(next_state);
      fifo_clear  <= (next_state == FLUSH);
      flush_done  <= (state == FLUSH);
      stall_abort <= abort_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter (MAX_STALL = 4).
module tb_fifo_wr_arbiter;

  logic       w_clk = 1'b0;
  logic       n_rst;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic       flush_req, flush_done;
  logic [7:0] fifo_w_data;
  logic       fifo_w_enable, fifo_clear, fifo_full, fifo_almost_full;
  logic [1:0] grant;
  logic       stall_abort;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter #(.MAX_STALL(4)) dut (
    .w_clk           (w_clk),
    .n_rst           (n_rst),
    .req0_data       (req0_data),
    .req0_valid      (req0_valid),
    .req0_last       (req0_last),
    .req0_ready      (req0_ready),
    .req1_data       (req1_data),
    .req1_valid      (req1_valid),
    .req1_last       (req1_last),
    .req1_ready      (req1_ready),
    .flush_req       (flush_req),
    .flush_done      (flush_done),
    .fifo_w_data     (fifo_w_data),
    .fifo_w_enable   (fifo_w_enable),
    .fifo_clear      (fifo_clear),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .grant           (grant),
    .stall_abort     (stall_abort)
  );

  typedef struct {
    logic       rst;
    logic       fl;
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       full;
    logic       af;
    logic [1:0] g;
    logic       r0;
    logic       r1;
    logic       we;
    logic [7:0] wd;
    logic       clr;
    logic       fd;
    logic       ab;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic fl,
                     input logic v0, input logic [7:0] d0, input logic l0,
                     input logic v1, input logic [7:0] d1, input logic l1,
                     input logic full, input logic af,
                     input logic [1:0] g, input logic r0, input logic r1,
                     input logic we, input logic [7:0] wd,
                     input logic clr, input logic fd, input logic ab);
    vec_t v;
    v = '{rst, fl, v0, d0, l0, v1, d1, l1, full, af, g, r0, r1, we, wd, clr, fd, ab};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h at %0t", name, row, act, exp, $time);
    end
  endtask

  task automatic check_all(input int row, input vec_t v);
    check("grant",       row, 8'(grant),         8'(v.g));
    check("req0_ready",  row, 8'(req0_ready),    8'(v.r0));
    check("req1_ready",  row, 8'(req1_ready),    8'(v.r1));
    check("w_enable",    row, 8'(fifo_w_enable), 8'(v.we));
    check("w_data",      row, fifo_w_data,       v.wd);
    check("fifo_clear",  row, 8'(fifo_clear),    8'(v.clr));
    check("flush_done",  row, 8'(flush_done),    8'(v.fd));
    check("stall_abort", row, 8'(stall_abort),   8'(v.ab));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t zero;
    int   seen;
    n_rst = 1'b0;
    {req0_valid, req0_last, req1_valid, req1_last} = '0;
    req0_data = '0; req1_data = '0;
    flush_req = 1'b0; fifo_full = 1'b0; fifo_almost_full = 1'b0;

    // rst fl  v0 d0     l0 v1 d1     l1 fu af  g      r0 r1 we wd     cl fd ab
    // single req0 packet 11,22,33 then bubble
    add(0,0, 1,8'h11,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'h11,0, 0,8'h00,0, 0,0, 2'b01,1,0,1,8'h11,0,0,0);
    add(0,0, 1,8'h22,0, 0,8'h00,0, 0,0, 2'b01,1,0,1,8'h22,0,0,0);
    add(0,0, 1,8'h33,1, 0,8'h00,0, 0,0, 2'b01,1,0,1,8'h33,0,0,0);
    add(0,0, 0,8'h00,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    // both valid from reset: req0, bubble, req1, bubble, req0
    add(1,0, 1,8'hA1,0, 1,8'hB1,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'hA1,0, 1,8'hB1,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'hA1,0, 1,8'hB1,0, 0,0, 2'b01,1,0,1,8'hA1,0,0,0);
    add(0,0, 1,8'hA2,1, 1,8'hB1,0, 0,0, 2'b01,1,0,1,8'hA2,0,0,0);
    add(0,0, 1,8'hA3,0, 1,8'hB1,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'hA3,0, 1,8'hB1,0, 0,0, 2'b10,0,1,1,8'hB1,0,0,0);
    add(0,0, 1,8'hA3,0, 1,8'hB2,1, 0,0, 2'b10,0,1,1,8'hB2,0,0,0);
    add(0,0, 1,8'hA3,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'hA3,0, 0,8'h00,0, 0,0, 2'b01,1,0,1,8'hA3,0,0,0);
    add(0,0, 1,8'hA4,1, 0,8'h00,0, 0,0, 2'b01,1,0,1,8'hA4,0,0,0);
    add(0,0, 0,8'h00,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    // fifo_full mid-packet: full cycles neither count nor clear the stall count
    add(0,0, 1,8'hC1,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'hC1,0, 0,8'h00,0, 0,0, 2'b01,1,0,1,8'hC1,0,0,0);
    add(0,0, 0,8'hC1,0, 0,8'h00,0, 0,0, 2'b01,1,0,0,8'hC1,0,0,0);
    add(0,0, 0,8'hC1,0, 0,8'h00,0, 1,0, 2'b01,0,0,0,8'hC1,0,0,0);
    add(0,0, 0,8'hC1,0, 0,8'h00,0, 1,0, 2'b01,0,0,0,8'hC1,0,0,0);
    add(0,0, 0,8'hC1,0, 0,8'h00,0, 1,0, 2'b01,0,0,0,8'hC1,0,0,0);
    add(0,0, 0,8'hC1,0, 0,8'h00,0, 1,0, 2'b01,0,0,0,8'hC1,0,0,0);
    add(0,0, 1,8'hC2,1, 0,8'h00,0, 1,0, 2'b01,0,0,0,8'hC2,0,0,0);
    add(0,0, 0,8'hC2,1, 0,8'h00,0, 0,0, 2'b01,1,0,0,8'hC2,0,0,0);
    add(0,0, 1,8'hC2,1, 0,8'h00,0, 0,0, 2'b01,1,0,1,8'hC2,0,0,0);
    add(0,0, 0,8'h00,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    // flush raised mid req1 packet, deferred until packet end
    add(0,0, 0,8'h00,0, 1,8'hD1,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,1, 0,8'h00,0, 1,8'hD1,0, 0,0, 2'b10,0,1,1,8'hD1,0,0,0);
    add(0,1, 0,8'h00,0, 1,8'hD2,1, 0,0, 2'b10,0,1,1,8'hD2,0,0,0);
    add(0,1, 1,8'hE1,1, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,1, 1,8'hE1,1, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,1,0,0);
    add(0,0, 1,8'hE1,1, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,1,0);
    add(0,0, 1,8'hE1,1, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'hE1,1, 0,8'h00,0, 0,0, 2'b01,1,0,1,8'hE1,0,0,0);
    add(0,0, 0,8'h00,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    // almost_full blocks new grants in IDLE
    add(0,0, 1,8'hF1,1, 0,8'h00,0, 0,1, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'hF1,1, 0,8'h00,0, 0,1, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'hF1,1, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'hF1,1, 0,8'h00,0, 0,0, 2'b01,1,0,1,8'hF1,0,0,0);
    add(0,0, 0,8'h00,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    // req1 stalls after one byte: abort after 4 stall cycles, req0 wins next
    add(0,0, 0,8'h00,0, 1,8'h61,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 0,8'h00,0, 1,8'h61,0, 0,0, 2'b10,0,1,1,8'h61,0,0,0);
    add(0,0, 1,8'h71,1, 0,8'h61,0, 0,0, 2'b10,0,1,0,8'h61,0,0,0);
    add(0,0, 1,8'h71,1, 0,8'h61,0, 0,0, 2'b10,0,1,0,8'h61,0,0,0);
    add(0,0, 1,8'h71,1, 0,8'h61,0, 0,0, 2'b10,0,1,0,8'h61,0,0,0);
    add(0,0, 1,8'h71,1, 0,8'h61,0, 0,0, 2'b10,0,1,0,8'h61,0,0,0);
    add(0,0, 1,8'h71,1, 1,8'h62,0, 0,0, 2'b00,0,0,0,8'h00,0,0,1);
    add(0,0, 1,8'h71,1, 1,8'h62,0, 0,0, 2'b01,1,0,1,8'h71,0,0,0);
    add(0,0, 0,8'h00,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    // reset while GNT1 with valid, then req0 wins the tie
    add(0,0, 0,8'h00,0, 1,8'h81,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 0,8'h00,0, 1,8'h81,0, 0,0, 2'b10,0,1,1,8'h81,0,0,0);
    add(1,0, 0,8'h00,0, 1,8'h82,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'h91,1, 1,8'h82,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);
    add(0,0, 1,8'h91,1, 1,8'h82,0, 0,0, 2'b01,1,0,1,8'h91,0,0,0);
    add(0,0, 0,8'h00,0, 0,8'h00,0, 0,0, 2'b00,0,0,0,8'h00,0,0,0);

    // outputs held low while reset is asserted before any edge
    #2;
    zero = '{default: '0};
    check_all(-1, zero);

    foreach (vq[i]) begin
      @(posedge w_clk);
      #1;
      n_rst            = !vq[i].rst;
      flush_req        = vq[i].fl;
      req0_valid       = vq[i].v0;
      req0_data        = vq[i].d0;
      req0_last        = vq[i].l0;
      req1_valid       = vq[i].v1;
      req1_data        = vq[i].d1;
      req1_last        = vq[i].l1;
      fifo_full        = vq[i].full;
      fifo_almost_full = vq[i].af;
      @(negedge w_clk);
      check_all(i, vq[i]);
    end

    // flush from IDLE: one clear cycle, then a single done pulse
    @(posedge w_clk);
    #1;
    flush_req = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge w_clk);
      if (fifo_clear) begin
        seen = 1;
        break;
      end
    end
    check("flush_clear_seen", 100, 8'(seen), 8'd1);
    check("flush_grant", 100, 8'(grant), 8'd0);
    @(posedge w_clk);
    #1;
    flush_req = 1'b0;
    @(negedge w_clk);
    check("flush_clear_one", 101, 8'(fifo_clear), 8'd0);
    check("flush_done_on", 101, 8'(flush_done), 8'd1);
    check("flush_done_gnt", 101, 8'(grant), 8'd0);
    @(posedge w_clk);
    #1;
    @(negedge w_clk);
    check("flush_done_off", 102, 8'(flush_done), 8'd0);
    check("flush_clear_off", 102, 8'(fifo_clear), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter MAX_STALL, default 15: stall-cycle limit (1..255) before a granted packet is aborted.
REQ-002 SHALL have port w_clk  input  1  write-domain clock, rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_data / req1_data  input  8  requester byte.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  byte offered.
REQ-006 SHALL have ports req0_last / req1_last  input  1  byte is final of packet.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  byte accepted this cycle when valid.
REQ-008 SHALL have port flush_req  input  1  level request to empty the FIFO.
REQ-009 SHALL have port flush_done  output  1  one-cycle pulse, flush complete.
REQ-010 SHALL have port fifo_w_data  output  8  to FIFO w_data.
REQ-011 SHALL have port fifo_w_enable  output  1  to FIFO w_enable.
REQ-012 SHALL have port fifo_clear  output  1  to FIFO clear.
REQ-013 SHALL have ports fifo_full / fifo_almost_full  input  1  FIFO status.
REQ-014 SHALL have port grant  output  2  one-hot owner: bit0 req0, bit1 req1, 00 none.
REQ-015 SHALL have port stall_abort  output  1  one-cycle pulse, granted packet aborted.

Function
REQ-016 SHALL implement FSM states IDLE, GNT0, GNT1, FLUSH.
REQ-017 IDLE SHALL go to FLUSH when flush_req=1; flush outranks all requesters.
REQ-018 IDLE with flush_req=0, fifo_full=0, fifo_almost_full=0 SHALL grant the sole valid requester; if both valid, grant the one not served last (rr pointer).
REQ-019 IDLE SHALL grant nothing while fifo_full or fifo_almost_full is 1.
REQ-020 grant SHALL be 01 in GNT0, 10 in GNT1, 00 otherwise.
REQ-021 reqN_ready SHALL be 1 only in GNTN with fifo_full=0; other ready 0.
REQ-022 Transfer = valid & ready; fifo_w_enable SHALL equal transfer, combinationally, same cycle.
REQ-023 fifo_w_data SHALL be the granted requester's data; 8'h00 when no grant.
REQ-024 Grant SHALL hold until a transfer with last=1; next state IDLE (one bubble cycle before any new grant); rr pointer then points to the other requester.
REQ-025 flush_req during GNTx SHALL be deferred until the packet ends or aborts.
REQ-026 FLUSH SHALL assert fifo_clear for exactly one cycle, then pulse flush_done in the next cycle in IDLE; no grant in the flush_done cycle.
REQ-027 A stall counter (8-bit) SHALL count GNTx cycles with valid=0 and fifo_full=0; it clears on transfer and on leaving GNTx; fifo_full cycles neither count nor clear.
REQ-028 When the counter reaches MAX_STALL, the FSM SHALL pulse stall_abort, return to IDLE, and pass rr priority to the other requester.
REQ-029 Abort SHALL not write the FIFO; bytes already written remain.
REQ-030 last with valid but not ready SHALL not end the packet.

Reset
REQ-031 On n_rst=0: state IDLE, rr pointer favours req0, stall counter 0.
REQ-032 During and after reset until the first edge: all outputs 0, grant 00.
REQ-033 Reset mid-packet SHALL drop the grant immediately; no fifo_w_enable generated.

Structure
REQ-034 State encoding and the GNT one-hot constants SHALL live in the shared package fifo_pkg.
REQ-035 The stall counter SHALL reuse flex_counter_reg (clear on transfer/exit, enable on stall, rollover MAX_STALL); no other submodules.

Verification
REQ-036 req0 sends 3 bytes 11,22,33 (last on 33), FIFO empty -> 3 consecutive fifo_w_enable, data 11,22,33, grant 01, then 00 one cycle.
REQ-037 req0 and req1 valid from reset, 2-byte packets each -> order req0 pkt, bubble, req1 pkt, bubble, req0 pkt.
REQ-038 fifo_full=1 for 4 cycles mid-packet -> ready 0, no write, no abort; packet completes after full drops.
REQ-039 flush_req raised mid-packet -> packet finishes, IDLE, fifo_clear 1 cycle, flush_done 1 cycle later.
REQ-040 MAX_STALL=4, req1 drops valid after byte 1 -> stall_abort pulse on 4th idle cycle, grant 00, req0 next winner.
REQ-041 n_rst asserted while GNT1 with valid=1 -> grant 00, fifo_w_enable 0 immediately; after release req0 wins a tie.
